// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the LCD timing generator.
//   * default 800x480 panel timing (clocks / lines)
//   * RGB565 colour-bar constants and the bar-index -> colour lookup
//   * pipeline depth and the per-pixel flag bundle that travels with a pixel
package lcd_pkg;

    // Default panel timing: horizontal in pixel clocks, vertical in lines.
    localparam int DEF_H_ACT    = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SW     = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACT    = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SW     = 3;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_SYNC_POL = 0;

    // Counter state -> LCD pins latency in clocks.
    localparam int PIPE_STAGES = 2;

    // Colour bars, left to right.
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Per-pixel side information carried alongside the active/valid bit.
    typedef struct packed {
        logic hsync;   // hcnt inside the horizontal sync window
        logic vsync;   // vcnt inside the vertical sync window
        logic first;   // pixel (0,0) of a frame
        logic pat;     // pixel belongs to a colour-bar frame
    } pix_flags_t;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_colorbar.sv
// lcd_colorbar -- combinational column -> RGB565 colour-bar lookup.
//   H_ACT : active pixels per line; the line is split into 8 equal bars.
//   col   : active column (0..H_ACT-1)
//   rgb   : RGB565 colour of the bar containing col
module lcd_colorbar
    import lcd_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT
) (
    input  logic [9:0]  col,
    output logic [15:0] rgb
);

    localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;

    logic [2:0] idx;

    // Threshold compare instead of a divider: idx = number of bar
    // boundaries at or left of col.
    always_comb begin
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(col) >= k * BAR_W) idx = 3'(k);
        end
    end

    assign rgb = bar_rgb(idx);

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen -- parallel RGB LCD timing generator with pixel fetch.
//
// Ports
//   LCD_CLK            pixel clock
//   RST                synchronous, active-high reset (overrides EN)
//   EN                 run enable; low holds/aborts the frame at (0,0)
//   PAT_EN             internal colour bars instead of fetched pixels,
//                      sampled at frame start
//   PIX_REQ/X/Y        pixel request and its coordinates (1 clock after
//                      counter state)
//   PIX_DATA/PIX_VALID RGB565 reply, sampled on the clock after PIX_REQ
//   LCD_HYNC/LCD_SYNC  hsync / vsync at SYNC_POL while asserted
//   LCD_DEN, LCD_R/G/B data enable and colour (2 clocks after counter state)
//   FRAME_START        one-clock pulse aligned with LCD_DEN of pixel (0,0)
//   UNDERFLOW          sticky: a requested pixel came back without PIX_VALID
//
// Pipeline
//   stage 0 : hcnt/vcnt and decoded flags (combinational)
//   stage 1 : PIX_REQ/X/Y out, flags registered, colour bar looked up
//   stage 2 : LCD pins registered, PIX_DATA captured
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SW     = DEF_H_SW,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SW     = DEF_V_SW,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = DEF_SYNC_POL
) (
    input  logic        LCD_CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        PAT_EN,
    output logic        PIX_REQ,
    output logic [9:0]  PIX_X,
    output logic [8:0]  PIX_Y,
    input  logic [15:0] PIX_DATA,
    input  logic        PIX_VALID,
    output logic        LCD_HYNC,
    output logic        LCD_SYNC,
    output logic        LCD_DEN,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        FRAME_START,
    output logic        UNDERFLOW
);

    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACT + H_FP + H_SW - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACT + V_FP + V_SW - 1);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    // ---------------- stage 0: raster counters ----------------
    // EN low parks the raster at (0,0), so raising EN always starts a
    // fresh frame and dropping it aborts the current one.
    always_ff @(posedge LCD_CLK) begin
        if (RST || !EN) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    logic       at_origin;
    logic       pat_mode;   // colour-bar mode latched for the running frame
    logic       pat_now;
    logic       act0;
    pix_flags_t flags0;

    // PAT_EN only counts at (0,0), so a frame is either all bars or all
    // fetched pixels.
    always_comb begin
        at_origin    = (hcnt == '0) && (vcnt == '0);
        pat_now      = at_origin ? PAT_EN : pat_mode;
        act0         = EN && (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        flags0.hsync = EN && (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
        flags0.vsync = EN && (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
        flags0.first = EN && at_origin;
        flags0.pat   = pat_now;
    end

    // Active bit shift register; the last stage is LCD_DEN itself.
    logic [PIPE_STAGES:1] vld_pipe;

    always_ff @(posedge LCD_CLK) begin
        if (RST) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[PIPE_STAGES-1:1], act0};
    end

    // ---------------- stage 1: request + flags ----------------
    pix_flags_t  flags1;
    logic [9:0]  col1;
    logic [15:0] bar1;

    always_ff @(posedge LCD_CLK) begin
        if (RST) begin
            flags1   <= '0;
            col1     <= '0;
            pat_mode <= 1'b0;
            PIX_REQ  <= 1'b0;
            PIX_X    <= '0;
            PIX_Y    <= '0;
        end else begin
            flags1   <= flags0;
            col1     <= 10'(hcnt);
            pat_mode <= pat_now;
            PIX_REQ  <= act0 && !pat_now;
            // Coordinates only move with a request; otherwise they hold.
            if (act0 && !pat_now) begin
                PIX_X <= 10'(hcnt);
                PIX_Y <= 9'(vcnt);
            end
        end
    end

    lcd_colorbar #(
        .H_ACT (H_ACT)
    ) u_colorbar (
        .col (col1),
        .rgb (bar1)
    );

    // ---------------- stage 2: LCD pins ----------------
    logic [15:0] rgb_next;
    logic        miss;

    // A missing reply on a fetched pixel is shown black and flagged;
    // bar frames never look at PIX_DATA/PIX_VALID.
    always_comb begin
        rgb_next = 16'h0000;
        miss     = 1'b0;
        if (vld_pipe[1]) begin
            if (flags1.pat)     rgb_next = bar1;
            else if (PIX_VALID) rgb_next = PIX_DATA;
            else                miss     = 1'b1;
        end
    end

    logic [15:0] rgb;

    always_ff @(posedge LCD_CLK) begin
        if (RST) begin
            rgb         <= '0;
            LCD_HYNC    <= !SYNC_ON;
            LCD_SYNC    <= !SYNC_ON;
            FRAME_START <= 1'b0;
            UNDERFLOW   <= 1'b0;
        end else begin
            rgb         <= rgb_next;
            LCD_HYNC    <= flags1.hsync ? SYNC_ON : !SYNC_ON;
            LCD_SYNC    <= flags1.vsync ? SYNC_ON : !SYNC_ON;
            FRAME_START <= flags1.first;
            UNDERFLOW   <= UNDERFLOW | miss;
        end
    end

    assign LCD_DEN = vld_pipe[PIPE_STAGES];
    assign LCD_R   = rgb[15:11];
    assign LCD_G   = rgb[10:5];
    assign LCD_B   = rgb[4:0];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a shrunken panel (16x6 active, 28x12 total).
// The reference model tracks the frame position as one integer and derives
// line/column, sync windows and expected colour from it with arithmetic.
module tb_lcd_timing_gen;

    localparam int H_ACT = 16, H_FP = 4, H_SW = 3, H_BP = 5;
    localparam int V_ACT = 6,  V_FP = 2, V_SW = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int BAR_W = H_ACT / 8;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk = 1'b0;
    logic        rst, en, pat_en, pix_valid;
    logic [15:0] pix_data;
    logic        pix_req, hyn, vsy, den, fstart, uflow;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [4:0]  lr, lb;
    logic [5:0]  lg;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP), .SYNC_POL(0)
    ) dut (
        .LCD_CLK(clk), .RST(rst), .EN(en), .PAT_EN(pat_en),
        .PIX_REQ(pix_req), .PIX_X(pix_x), .PIX_Y(pix_y),
        .PIX_DATA(pix_data), .PIX_VALID(pix_valid),
        .LCD_HYNC(hyn), .LCD_SYNC(vsy), .LCD_DEN(den),
        .LCD_R(lr), .LCD_G(lg), .LCD_B(lb),
        .FRAME_START(fstart), .UNDERFLOW(uflow)
    );

    typedef struct {
        bit den, hs, vs, fs, pat;
        int h, v;
    } ent_t;

    int   passed = 0, total = 0, failed = 0;
    ent_t pend;                 // model pixel currently in stage 1
    int   mpos;                 // model position within the frame
    bit   mmode, muf;
    int   mx, my;
    int   drop_h = -1, drop_v = -1, drop_pct = 0;
    int   den_cnt, fs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] echo(input int x, input int y);
        logic [9:0] xb;
        logic [8:0] yb;
        xb = 10'(x);
        yb = 9'(y);
        return {yb[4:0], xb[5:0], xb[4:0]};
    endfunction

    function automatic ent_t idle_ent();
        ent_t e;
        e.den = 0; e.hs = 0; e.vs = 0; e.fs = 0; e.pat = 0; e.h = 0; e.v = 0;
        return e;
    endfunction

    function automatic ent_t make_ent(input int pos, input bit mode);
        ent_t e;
        e.h   = pos % H_TOT;
        e.v   = pos / H_TOT;
        e.den = (e.h < H_ACT) && (e.v < V_ACT);
        e.hs  = (e.h >= H_ACT + H_FP) && (e.h < H_ACT + H_FP + H_SW);
        e.vs  = (e.v >= V_ACT + V_FP) && (e.v < V_ACT + V_FP + V_SW);
        e.fs  = (pos == 0);
        e.pat = mode;
        return e;
    endfunction

    // One clock: drive inputs at the falling edge, play the pixel source,
    // advance the model, then check everything 1 time unit after the edge.
    task automatic tick(input bit r, input bit e, input bit p);
        ent_t        cur, nxt;
        logic [15:0] exp_rgb;
        rst = r; en = e; pat_en = p;
        cur = pend;
        if (pix_req) begin
            pix_valid = !((cur.h == drop_h && cur.v == drop_v) ||
                          (int'($urandom_range(99)) < drop_pct));
            pix_data  = echo(int'(pix_x), int'(pix_y));
        end else begin
            pix_valid = 1'($urandom_range(1));
            pix_data  = 16'($urandom);
        end
        exp_rgb = 16'h0;
        if (cur.den) begin
            if (cur.pat)        exp_rgb = BARS[cur.h / BAR_W];
            else if (pix_valid) exp_rgb = echo(cur.h, cur.v);
            else                muf = 1;
        end
        if (r) begin
            cur = idle_ent(); nxt = idle_ent(); exp_rgb = 16'h0;
            mpos = 0; mmode = 0; muf = 0; mx = 0; my = 0;
        end else if (!e) begin
            nxt = idle_ent(); mpos = 0;
        end else begin
            if (mpos == 0) mmode = p;
            nxt  = make_ent(mpos, mmode);
            mpos = (mpos + 1) % FRAME;
            if (nxt.den && !nxt.pat) begin mx = nxt.h; my = nxt.v; end
        end
        @(posedge clk); #1;
        chk("den",   32'(den),    32'(cur.den));
        chk("hsync", 32'(hyn),    32'(!cur.hs));
        chk("vsync", 32'(vsy),    32'(!cur.vs));
        chk("fstart",32'(fstart), 32'(cur.fs));
        chk("rgb",   32'({lr, lg, lb}), 32'(exp_rgb));
        chk("uflow", 32'(uflow),  32'(muf));
        chk("req",   32'(pix_req), 32'(nxt.den && !nxt.pat));
        chk("pix_x", 32'(pix_x),  32'(mx));
        chk("pix_y", 32'(pix_y),  32'(my));
        if (den)    den_cnt++;
        if (fstart) fs_cnt++;
        pend = nxt;
        @(negedge clk);
    endtask

    initial begin
        bit pat_r;
        rst = 1; en = 0; pat_en = 0; pix_valid = 0; pix_data = '0;
        pend = idle_ent(); mpos = 0; mmode = 0; muf = 0; mx = 0; my = 0;
        @(negedge clk);

        // Reset, with EN random to show reset wins.
        repeat (3) tick(1, 1'($urandom_range(1)), 0);

        // First full frame of fetched pixels.
        den_cnt = 0; fs_cnt = 0;
        repeat (FRAME) tick(0, 1, 0);
        chk("den_per_frame", 32'(den_cnt), 32'(H_ACT * V_ACT));
        chk("fs_per_frame",  32'(fs_cnt),  32'd1);

        // Missing reply on pixel (5,0) only: black pixel, sticky flag.
        drop_h = 5; drop_v = 0;
        repeat (FRAME) tick(0, 1, 0);
        drop_h = -1; drop_v = -1;
        repeat (40) tick(0, 1, 0);
        chk("uflow_sticky", 32'(uflow), 32'd1);
        repeat (2) tick(1, 1, 0);
        chk("uflow_cleared", 32'(uflow), 32'd0);

        // Bars requested mid-frame: take effect at the next frame start.
        repeat (50) tick(0, 1, 0);
        den_cnt = 0;
        repeat (FRAME + 20) tick(0, 1, 1);
        repeat (FRAME) tick(0, 1, 0);

        // Abort at (9,3), hold off briefly, restart.
        for (int i = 0; i < FRAME && mpos != 3 * H_TOT + 9; i++) tick(0, 1, 0);
        chk("abort_point", 32'(mpos), 32'(3 * H_TOT + 9));
        repeat (3) tick(0, 0, 0);
        fs_cnt = 0;
        repeat (40) tick(0, 1, 0);
        chk("restart_fs", 32'(fs_cnt), 32'd1);

        // Random EN glitches, PAT_EN flips and missing replies.
        drop_pct = 5;
        pat_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(299) == 0) pat_r = !pat_r;
            tick(0, $urandom_range(149) != 0, pat_r);
        end
        drop_pct = 0;
        repeat (2) tick(1, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
